// File: rtl/x1_input_conditioner_pkg.sv
// Shared definitions for the x1 input conditioner: FSM state codes and default debounce length.
package x1_input_conditioner_pkg;

  // LOW=00, CHK_HIGH=01, HIGH=11, CHK_LOW=10; all four codes are used, so no illegal states.
  typedef enum logic [1:0] {
    StLow     = 2'b00,
    StChkHigh = 2'b01,
    StHigh    = 2'b11,
    StChkLow  = 2'b10
  } state_e;

  localparam int unsigned DefaultDebounceCycles = 16;

endpackage

// File: rtl/x1_input_conditioner_if.sv
// Signal bundle between the raw-input source and the conditioner outputs.
interface x1_input_conditioner_if #(
  parameter int unsigned GLITCH_W = 8
);
  logic                din_raw;
  logic                x1;
  logic                rise_pulse;
  logic                fall_pulse;
  logic                stable;
  logic [GLITCH_W-1:0] glitch_count;

  modport master (
    output din_raw,
    input  x1,
    input  rise_pulse,
    input  fall_pulse,
    input  stable,
    input  glitch_count
  );

  modport slave (
    input  din_raw,
    output x1,
    output rise_pulse,
    output fall_pulse,
    output stable,
    output glitch_count
  );
endinterface

// File: rtl/x1_input_conditioner_input_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
module x1_input_conditioner_input_sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw level through the chain; only the last stage is used downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/x1_input_conditioner.sv
// Synchronises and debounces a raw input into a clean x1 level with edge pulses and a
// saturating count of rejected level changes.
module x1_input_conditioner
  import x1_input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned CNT_W           = 5,
  parameter int unsigned GLITCH_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  x1_input_conditioner_if.slave bus_io
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                s_in;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                x1_q, x1_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                stable_q, stable_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  x1_input_conditioner_input_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (bus_io.din_raw),
    .q_o  (s_in)
  );

  // State and all outputs are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StLow;
      cnt_q    <= '0;
      x1_q     <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      stable_q <= 1'b1;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x1_q     <= x1_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      stable_q <= stable_d;
      glitch_q <= glitch_d;
    end
  end

  // Next-state logic; a level reversal takes priority over reaching the qualification count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x1_d     = x1_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    stable_d = stable_q;
    glitch_d = glitch_q;
    unique case (state_q)
      StLow: begin
        if (s_in) begin
          state_d  = StChkHigh;
          cnt_d    = '0;
          stable_d = 1'b0;
        end
      end
      StChkHigh: begin
        if (!s_in) begin
          state_d  = StLow;
          cnt_d    = '0;
          stable_d = 1'b1;
          if (glitch_q != '1) glitch_d = glitch_q + 1'b1;
        end else if (cnt_q == CntMax) begin
          state_d  = StHigh;
          cnt_d    = '0;
          x1_d     = 1'b1;
          rise_d   = 1'b1;
          stable_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (!s_in) begin
          state_d  = StChkLow;
          cnt_d    = '0;
          stable_d = 1'b0;
        end
      end
      StChkLow: begin
        if (s_in) begin
          state_d  = StHigh;
          cnt_d    = '0;
          stable_d = 1'b1;
          if (glitch_q != '1) glitch_d = glitch_q + 1'b1;
        end else if (cnt_q == CntMax) begin
          state_d  = StLow;
          cnt_d    = '0;
          x1_d     = 1'b0;
          fall_d   = 1'b1;
          stable_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign bus_io.x1           = x1_q;
  assign bus_io.rise_pulse   = rise_q;
  assign bus_io.fall_pulse   = fall_q;
  assign bus_io.stable       = stable_q;
  assign bus_io.glitch_count = glitch_q;

endmodule

// File: tb/tb_x1_input_conditioner.sv
// Directed bench for x1_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, GLITCH_W=3.
module tb_x1_input_conditioner;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  x1_input_conditioner_if #(.GLITCH_W(3)) bus ();

  x1_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (5),
    .GLITCH_W       (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive din_raw, take one rising edge (which samples it), and settle 1 time unit after it.
  task automatic step(input logic din);
    bus.din_raw = din;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.din_raw = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.din_raw = 1'b0;
    #2;
    reset = 1'b1;
    #1;  // time 3, before any clock edge
    total_cnt++;
    if (bus.x1 !== 1'b0) $display("FAIL reset_x1 got=%b exp=0", bus.x1); else pass_cnt++;
    total_cnt++;
    if (bus.rise_pulse !== 1'b0) $display("FAIL reset_rise got=%b exp=0", bus.rise_pulse);
    else pass_cnt++;
    total_cnt++;
    if (bus.fall_pulse !== 1'b0) $display("FAIL reset_fall got=%b exp=0", bus.fall_pulse);
    else pass_cnt++;
    total_cnt++;
    if (bus.stable !== 1'b1) $display("FAIL reset_stable got=%b exp=1", bus.stable); else pass_cnt++;
    total_cnt++;
    if (bus.glitch_count !== 3'd0) $display("FAIL reset_glitch got=%0d exp=0", bus.glitch_count);
    else pass_cnt++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0);
  endtask

  task automatic test_clean_rise();
    // Edge k is the first call; x1 rises after edge k+6 (7th call).
    for (int i = 1; i <= 6; i++) begin
      step(1'b1);
      if (i >= 3) begin
        total_cnt++;
        if (bus.stable !== 1'b0) $display("FAIL rise_stable_low call=%0d got=%b exp=0", i, bus.stable);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (bus.x1 !== 1'b0) $display("FAIL rise_x1_early got=%b exp=0", bus.x1); else pass_cnt++;
    step(1'b1);
    total_cnt++;
    if ({bus.x1, bus.rise_pulse, bus.fall_pulse, bus.stable} !== 4'b1101)
      $display("FAIL rise_edge got=%b exp=1101", {bus.x1, bus.rise_pulse, bus.fall_pulse, bus.stable});
    else pass_cnt++;
    step(1'b1);
    total_cnt++;
    if ({bus.x1, bus.rise_pulse} !== 2'b10)
      $display("FAIL rise_pulse_clear got=%b exp=10", {bus.x1, bus.rise_pulse});
    else pass_cnt++;
  endtask

  task automatic test_clean_fall();
    for (int i = 1; i <= 6; i++) step(1'b0);
    total_cnt++;
    if ({bus.x1, bus.fall_pulse} !== 2'b10)
      $display("FAIL fall_early got=%b exp=10", {bus.x1, bus.fall_pulse});
    else pass_cnt++;
    step(1'b0);
    total_cnt++;
    if ({bus.x1, bus.rise_pulse, bus.fall_pulse, bus.stable} !== 4'b0011)
      $display("FAIL fall_edge got=%b exp=0011", {bus.x1, bus.rise_pulse, bus.fall_pulse, bus.stable});
    else pass_cnt++;
    step(1'b0);
    total_cnt++;
    if (bus.fall_pulse !== 1'b0) $display("FAIL fall_pulse_clear got=%b exp=0", bus.fall_pulse);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic seen_rise;
    seen_rise = 1'b0;
    for (int i = 0; i < 4; i++) begin step(1'b1); seen_rise |= bus.rise_pulse; end
    for (int i = 0; i < 6; i++) begin step(1'b0); seen_rise |= bus.rise_pulse; end
    total_cnt++;
    if ({bus.x1, seen_rise} !== 2'b00)
      $display("FAIL glitch4_x1 got=%b exp=00", {bus.x1, seen_rise});
    else pass_cnt++;
    total_cnt++;
    if (bus.glitch_count !== 3'd1) $display("FAIL glitch4_count got=%0d exp=1", bus.glitch_count);
    else pass_cnt++;
    seen_rise = 1'b0;
    for (int i = 0; i < 5; i++) begin step(1'b1); seen_rise |= bus.rise_pulse; end
    for (int i = 0; i < 2; i++) begin step(1'b0); seen_rise |= bus.rise_pulse; end
    total_cnt++;
    if ({bus.x1, seen_rise} !== 2'b11)
      $display("FAIL glitch5_accept got=%b exp=11", {bus.x1, seen_rise});
    else pass_cnt++;
    total_cnt++;
    if (bus.glitch_count !== 3'd1) $display("FAIL glitch5_count got=%0d exp=1", bus.glitch_count);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) step(1'b0);
    total_cnt++;
    if (bus.x1 !== 1'b0) $display("FAIL glitch5_return got=%b exp=0", bus.x1); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int exp_cnt;
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      step(1'b1);
      step(1'b1);
      for (int j = 0; j < 4; j++) step(1'b0);
      exp_cnt = (i > 7) ? 7 : i;
      total_cnt++;
      if (bus.glitch_count !== 3'(exp_cnt))
        $display("FAIL sat_count n=%0d got=%0d exp=%0d", i, bus.glitch_count, exp_cnt);
      else pass_cnt++;
    end
    total_cnt++;
    if (bus.x1 !== 1'b0) $display("FAIL sat_x1 got=%b exp=0", bus.x1); else pass_cnt++;
  endtask

  task automatic test_reset_mid_qual();
    logic seen_rise;
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1);  // now CHK_HIGH with cnt=2
    total_cnt++;
    if (bus.stable !== 1'b0) $display("FAIL midq_qualifying got=%b exp=0", bus.stable);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    bus.din_raw = 1'b0;
    #1;
    total_cnt++;
    if ({bus.x1, bus.rise_pulse, bus.stable} !== 3'b001)
      $display("FAIL midq_async got=%b exp=001", {bus.x1, bus.rise_pulse, bus.stable});
    else pass_cnt++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen_rise = 1'b0;
    for (int i = 0; i < 8; i++) begin step(1'b0); seen_rise |= bus.rise_pulse; end
    total_cnt++;
    if ({bus.x1, seen_rise, bus.stable} !== 3'b001)
      $display("FAIL midq_after got=%b exp=001", {bus.x1, seen_rise, bus.stable});
    else pass_cnt++;
    total_cnt++;
    if (bus.glitch_count !== 3'd0) $display("FAIL midq_glitch got=%0d exp=0", bus.glitch_count);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_glitch();
    test_saturation();
    test_reset_mid_qual();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
